// File: rtl/fpnew_hub_result_fifo.sv
// Result buffer between a HUB opgroup format slice and the opgroup output arbiter.
// Optional zero-latency empty path: define FPNEW_HUB_RESULT_FIFO_BYPASS_EN.
package fpnew_pkg;
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;
endpackage

module fpnew_hub_result_fifo
    import fpnew_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2,
    parameter type TagType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [Width-1:0]           result_i,
    input  status_t                    status_i,
    input  logic                       extension_bit_i,
    input  TagType                     tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Width-1:0]           result_o,
    output status_t                    status_o,
    output logic                       extension_bit_o,
    output TagType                     tag_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       busy_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext;
        TagType           tag;
    } entry_t;

    entry_t mem_q [Depth];
    ptr_t   wr_ptr_q;
    ptr_t   rd_ptr_q;
    cnt_t   count_q;

    entry_t in_entry;
    entry_t head;
    logic   full;
    logic   empty;
    logic   bypass;
    logic   push;
    logic   pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign in_entry = '{
        result: result_i,
        status: status_i,
        ext:    extension_bit_i,
        tag:    tag_i
    };

    assign full  = (count_q == cnt_t'(Depth));
    assign empty = (count_q == '0);

`ifdef FPNEW_HUB_RESULT_FIFO_BYPASS_EN
    assign bypass = empty & in_valid_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed item taken by the arbiter never occupies a slot.
    assign push = in_valid_i & ~full & ~flush_i & ~(bypass & out_ready_i);
    assign pop  = ~empty & out_ready_i & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + cnt_t'(1);
            end else if (pop && !push) begin
                count_q <= count_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign head = bypass ? in_entry : mem_q[rd_ptr_q];

    assign result_o        = head.result;
    assign status_o        = head.status;
    assign extension_bit_o = head.ext;
    assign tag_o           = head.tag;

    assign in_ready_o  = ~full;
    assign out_valid_o = ~empty | bypass;
    assign busy_o      = ~empty | bypass;
    assign count_o     = count_q;

endmodule

// File: tb/tb_fpnew_hub_result_fifo.sv
// Bench for fpnew_hub_result_fifo: Depth=2 and Depth=4 instances on shared stimulus.
// Vector table for the Depth=2 corner cases plus a queue model checked every cycle.
module tb_fpnew_hub_result_fifo;
    import fpnew_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  s;
        logic        e;
        logic        t;
    } item_t;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic [4:0]  st;
        logic        tg;
        logic        ordy;
        logic        ev;
        logic [1:0]  ec;
        logic        er;
        logic [31:0] eh;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic        ext;
    logic        tag;
    logic [31:0] result;
    status_t     status;

    logic        a_in_ready, a_out_valid, a_ext, a_tag, a_busy;
    logic [31:0] a_result;
    status_t     a_status;
    logic [1:0]  a_count;

    logic        b_in_ready, b_out_valid, b_ext, b_tag, b_busy;
    logic [31:0] b_result;
    status_t     b_status;
    logic [2:0]  b_count;

    int    checks = 0;
    int    errors = 0;
    item_t qa[$];
    item_t qb[$];
    logic [31:0] b_got[$];
    bit    mon_en = 1'b0;
    bit    rec_b = 1'b0;
    vec_t  vecs[14];

    always #5 clk = ~clk;

    fpnew_hub_result_fifo #(.Width(32), .Depth(2), .TagType(logic)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready),
        .result_i(result), .status_i(status),
        .extension_bit_i(ext), .tag_i(tag),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready),
        .result_o(a_result), .status_o(a_status),
        .extension_bit_o(a_ext), .tag_o(a_tag),
        .count_o(a_count), .busy_o(a_busy)
    );

    fpnew_hub_result_fifo #(.Width(32), .Depth(4), .TagType(logic)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(b_in_ready),
        .result_i(result), .status_i(status),
        .extension_bit_i(ext), .tag_i(tag),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready),
        .result_o(b_result), .status_o(b_status),
        .extension_bit_o(b_ext), .tag_o(b_tag),
        .count_o(b_count), .busy_o(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] d,
                         input logic [4:0] st, input logic tg, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        result    = d;
        status    = status_t'(st);
        tag       = tg;
        ext       = tg ^ d[0];
        out_ready = ordy;
    endtask

    // Reference queues: one per instance, capacity 2 and 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            automatic item_t it = '{r: result, s: 5'(status), e: ext, t: tag};
            automatic bit pa = (qa.size() != 0) && out_ready;
            automatic bit ca = in_valid && (qa.size() != 2);
            automatic bit pb = (qb.size() != 0) && out_ready;
            automatic bit cb = in_valid && (qb.size() != 4);
            if (pa) void'(qa.pop_front());
            if (ca) qa.push_back(it);
            if (pb) void'(qb.pop_front());
            if (cb) qb.push_back(it);
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("a_valid", 32'(a_out_valid), 32'(qa.size() != 0));
            chk("a_count", 32'(a_count), 32'(qa.size()));
            chk("a_ready", 32'(a_in_ready), 32'(qa.size() != 2));
            chk("a_busy", 32'(a_busy), 32'(qa.size() != 0));
            if (qa.size() != 0) begin
                chk("a_result", a_result, qa[0].r);
                chk("a_status", 32'({a_status}), 32'(qa[0].s));
                chk("a_ext", 32'(a_ext), 32'(qa[0].e));
                chk("a_tag", 32'(a_tag), 32'(qa[0].t));
            end
            chk("b_valid", 32'(b_out_valid), 32'(qb.size() != 0));
            chk("b_count", 32'(b_count), 32'(qb.size()));
            chk("b_ready", 32'(b_in_ready), 32'(qb.size() != 4));
            chk("b_busy", 32'(b_busy), 32'(qb.size() != 0));
            if (qb.size() != 0) begin
                chk("b_result", b_result, qb[0].r);
                chk("b_status", 32'({b_status}), 32'(qb[0].s));
                chk("b_ext", 32'(b_ext), 32'(qb[0].e));
                chk("b_tag", 32'(b_tag), 32'(qb[0].t));
            end
            if (a_out_valid) chk("a_no_dead", 32'(a_result != 32'hDEAD), 32'd1);
            if (b_out_valid) chk("b_no_dead", 32'(b_result != 32'hDEAD), 32'd1);
            if (rec_b && b_out_valid && out_ready) b_got.push_back(b_result);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        automatic bit acc = 1'b0;
        automatic logic [31:0] v = '0;

        vecs[0]  = '{1'b0, 1'b1, 32'h1,  5'h01, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 32'h1};
        vecs[1]  = '{1'b0, 1'b1, 32'h2,  5'h02, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h1};
        vecs[2]  = '{1'b0, 1'b1, 32'h3,  5'h03, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h1};
        vecs[3]  = '{1'b0, 1'b1, 32'h3,  5'h03, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 32'h2};
        vecs[4]  = '{1'b0, 1'b1, 32'h3,  5'h03, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h2};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,  5'h00, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h3};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,  5'h00, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'hA,  5'h0A, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'hA};
        vecs[8]  = '{1'b0, 1'b1, 32'hB,  5'h0B, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'hA};
        vecs[9]  = '{1'b0, 1'b1, 32'hC,  5'h0C, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hB};
        vecs[10] = '{1'b1, 1'b1, 32'hDEAD, 5'h1F, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  5'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 32'h3F80_0000, 5'h01, 1'b1, 1'b1,
                     1'b1, 2'd1, 1'b1, 32'h3F80_0000};
        vecs[13] = '{1'b0, 1'b0, 32'h0,  5'h00, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_count", 32'(a_count), 32'd0);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_ready", 32'(a_in_ready), 32'd1);
        chk("rst_a_result", a_result, 32'd0);
        chk("rst_a_status", 32'({a_status}), 32'd0);
        chk("rst_a_ext", 32'(a_ext), 32'd0);
        chk("rst_a_tag", 32'(a_tag), 32'd0);
        chk("rst_b_count", 32'(b_count), 32'd0);
        chk("rst_b_ready", 32'(b_in_ready), 32'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i <= 14; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                chk($sformatf("vec%0d_valid", i - 1), 32'(a_out_valid), 32'(vecs[i-1].ev));
                chk($sformatf("vec%0d_count", i - 1), 32'(a_count), 32'(vecs[i-1].ec));
                chk($sformatf("vec%0d_ready", i - 1), 32'(a_in_ready), 32'(vecs[i-1].er));
                chk($sformatf("vec%0d_busy", i - 1), 32'(a_busy), 32'(vecs[i-1].ev));
                if (vecs[i-1].ev)
                    chk($sformatf("vec%0d_head", i - 1), a_result, vecs[i-1].eh);
            end
            if (i < 14)
                drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].st, vecs[i].tg, vecs[i].ordy);
            else
                drive(1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
        end

        // Depth-4 streaming of 0..9 against alternating back-pressure.
        rec_b = 1'b1;
        for (int k = 0; k < 200 && b_got.size() < 10; k++) begin
            @(posedge clk);
            #1;
            if (acc) v = v + 32'd1;
            acc = (v < 32'd10) && (qb.size() < 4);
            drive(1'b0, v < 32'd10, v, v[4:0], v[0], k[0]);
        end
        rec_b = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b1);
        chk("stream_len", 32'(b_got.size()), 32'd10);
        for (int i = 0; i < b_got.size() && i < 10; i++)
            chk($sformatf("stream_item%0d", i), b_got[i], 32'(i));
        repeat (4) @(posedge clk);
        #1;

        // Async reset with two entries held.
        drive(1'b0, 1'b1, 32'h21, 5'h01, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 32'h22, 5'h02, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(a_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a_valid", 32'(a_out_valid), 32'd0);
        chk("arst_a_count", 32'(a_count), 32'd0);
        chk("arst_a_busy", 32'(a_busy), 32'd0);
        chk("arst_a_ready", 32'(a_in_ready), 32'd1);
        chk("arst_b_valid", 32'(b_out_valid), 32'd0);
        chk("arst_b_count", 32'(b_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 32'h7, 5'h07, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b1);
        chk("post_rst_valid", 32'(a_out_valid), 32'd1);
        chk("post_rst_first", a_result, 32'h7);
        @(posedge clk);
        #1;
        chk("post_rst_drained", 32'(a_count), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpnew_hub_result_fifo.md
# fpnew_hub_result_fifo

Output buffer placed directly downstream of a HUB opgroup format slice: it captures each completed result (result, status flags, extension bit, tag) on a valid/ready handshake and presents it to the opgroup output arbiter in FIFO order. It decouples the slice's `out_ready_i` from arbiter back-pressure, so the HUB adder, multiplier and divider wrappers can retire results while the arbiter serves another format. It supports flush and reports occupancy for the FPU-level busy signal.

## Interface
- `Width`, default 32, width of the result word; it must match the slice `Width`.
- `Depth`, default 2, number of entries; legal range is 1..16.
- `TagType`, default `logic`, type of the operation tag carried alongside each result.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  synchronous flush; discards all entries.
- `in_valid_i`  in  1  slice result valid.
- `in_ready_o`  out  1  buffer can accept a result.
- `result_i`  in  Width  slice result word.
- `status_i`  in  `fpnew_pkg::status_t` (5)  IEEE flags {NV,DZ,OF,UF,NX}.
- `extension_bit_i`  in  1  slice extension bit.
- `tag_i`  in  TagType  operation tag.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  arbiter accepts the head entry.
- `result_o`  out  Width  head result.
- `status_o`  out  5  head status.
- `extension_bit_o`  out  1  head extension bit.
- `tag_o`  out  TagType  head tag.
- `count_o`  out  $clog2(Depth+1)  current occupancy.
- `busy_o`  out  1  high when `count_o` is nonzero.

## Operation
- Storage is `Depth` entries of {result, status, ext bit, tag}, addressed by a write pointer, a read pointer and an occupancy counter.
- **Push:** occurs when `in_valid_i & in_ready_o`. The entry is written at the write pointer, and the write pointer advances, wrapping from `Depth-1` to 0.
- **Pop:** occurs when `out_valid_o & out_ready_i`. The read pointer advances with the same wrap rule.
- **Occupancy:** `count_o` changes by +1 on a push only, by −1 on a pop only, and is unchanged on a simultaneous push and pop.
- **Ready:** `in_ready_o = (count_o != Depth)`. It has no combinational dependency on `out_ready_i`.
  - When full, a simultaneous pop does not admit a push in the same cycle.
- **Valid:** `out_valid_o = (count_o != 0)`.
- **Head outputs:** `result_o`, `status_o`, `extension_bit_o` and `tag_o` always reflect the entry at the read pointer. They are only meaningful while `out_valid_o` is high; the bench must not check them otherwise.
- **Flush:** `flush_i` takes priority over push and pop. On the next edge both pointers and the counter reset to 0, and any push presented in the flush cycle is dropped.
- **Illegal input:** `in_valid_i` while `in_ready_o` is low is legal. The request is simply not taken, and the source must hold its data.
- **Reset mid-operation:** all contents are lost immediately, asynchronously.

## Timing
- Reset values:
  - `count_o = 0`, `out_valid_o = 0`, `busy_o = 0`, `in_ready_o = 1`.
  - All storage is cleared to 0, so `result_o`, `status_o`, `extension_bit_o` and `tag_o` read as 0.
- Latency without bypass: a result pushed at edge N is visible at `out_valid_o` from edge N, i.e. one cycle after `in_valid_i` was sampled.
- Throughput is one result per cycle when `Depth ≥ 2`.
- With `Depth = 1`, throughput is one result per two cycles, because a full buffer cannot be refilled in its pop cycle.
- `in_ready_o`, `out_valid_o`, `count_o` and `busy_o` are pure register decodes with no input-to-output combinational path (bypass disabled).

## Configuration
- Macro: `FPNEW_HUB_RESULT_FIFO_BYPASS_EN`.
- **Defined:** when `count_o == 0` and `in_valid_i` is high, the input passes through combinationally.
  - `out_valid_o` is driven high and the head outputs equal the inputs.
  - If `out_ready_i` is also high, the item is consumed that cycle without being written, and `count_o` stays 0.
  - If `out_ready_i` is low, the item is written normally.
  - Result: zero-cycle latency on the empty path.
  - `busy_o` also goes high during a bypass cycle.
- **Undefined:** there is no bypass path; behaviour is exactly as specified in Operation and Timing.

## Test plan
- **Reset, then single push.** Push `result_i=32'h3F80_0000`, `status_i=5'b00001`, `tag_i=1` at cycle 1, with `out_ready_i=1`. Expected: `out_valid_o=1` in cycle 2 with the same data, then `count_o` returns to 0 in cycle 3 (bypass off). With bypass on: `out_valid_o=1` in cycle 1 and `count_o` stays 0.
- **Fill to full.** With `Depth=2` and `out_ready_i=0`, push A=1, B=2 and attempt C=3. Expected: `in_ready_o=0` after two pushes, and `count_o=2`. Then drain: results appear in order 1, 2, and C is accepted only once `in_ready_o` rises, appearing third.
- **Steady streaming.** With `Depth=4`, push 0..9 continuously with `out_ready_i` toggling 1,0,1,0. Expected: outputs are 0..9 in order with no loss or duplication, `count_o` never exceeds 4, and pointers wrap correctly.
- **Flush with simultaneous push.** With `count_o=3`, assert `flush_i` and `in_valid_i` (value `32'hDEAD`) in the same cycle. Expected: next cycle `count_o=0` and `out_valid_o=0`, and `32'hDEAD` never appears at the output.
- **Asynchronous reset mid-stream.** Hold `count_o=2`, then assert `rst_ni=0` between edges. Expected: `out_valid_o`, `count_o` and `busy_o` drop to 0 immediately and `in_ready_o=1`. After release, a new push of value 7 emerges as the first output.
- **Full with simultaneous pop and push attempt.** With `count_o=2` and `Depth=2`, apply `out_ready_i=1` and `in_valid_i=1`. Expected: a pop only, `count_o=1` next cycle, and the push is accepted in the following cycle.
